fifo_sync: RTL and testbench
============================

# fifo_sync

Parametrised single-clock FIFO that supersedes the fixed-size FIFO in the buffering path. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds and registered overflow/underflow pulses with sticky error capture. It sits between a producer and consumer in the same clock domain and keeps the established flag contract: reset forces empty=1 and clears full, overflow, underflow and rdata.

## Interface
- DATA_WIDTH, 8: width of wdata/rdata.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- CW (localparam), $clog2(DEPTH+1): count width.

- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wdata  in  DATA_WIDTH  write data, sampled on an accepted write.
- rd_en  in  1  read request.
- clr_err  in  1  clears the sticky error bits.
- rdata  out  DATA_WIDTH  read data, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CW  current occupancy.
- overflow  out  1  one-cycle pulse after a rejected write.
- underflow  out  1  one-cycle pulse after a rejected read.
- err_sticky  out  2  {underflow seen, overflow seen}; held until clr_err.

## Operation
- Pointers wr_ptr/rd_ptr are log2(DEPTH)+1 bits wide. The extra MSB distinguishes full from empty. Pointers wrap naturally modulo 2·DEPTH.
- A write is accepted iff wr_en && !full. A read is accepted iff rd_en && !empty. Both decisions use the flag values registered at the current edge.
- Accepted write: mem[wr_ptr] ← wdata, wr_ptr+1.
- Accepted read: rdata ← mem[rd_ptr], rd_ptr+1. rdata holds its value on all other cycles.
- count is updated by +1 for a lone accepted write, −1 for a lone accepted read, and 0 when both or neither are accepted.
- Simultaneous wr_en && rd_en while full: the read is accepted and the write is rejected, so overflow pulses and count becomes DEPTH−1.
- Simultaneous wr_en && rd_en while empty: the write is accepted and the read is rejected, so underflow pulses and count becomes 1.
- Otherwise, simultaneous requests are both accepted and count is unchanged.
- Rejected requests leave memory, pointers and rdata untouched.
- err_sticky[0] is set on any overflow pulse and err_sticky[1] on any underflow pulse. clr_err clears both; a set in the same cycle as clr_err wins.
- full, empty, almost_full, almost_empty and count are registered and consistent with each other every cycle. full and empty are never both 1.

## Timing
- Reset (rst=0, asynchronous): count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, err_sticky=0, rdata=0, pointers=0. Memory contents are not reset.
- Reset deasserts synchronously to clk. A reset mid-operation discards all contents.
- Write-to-flag latency: flags and count reflect a write on the edge that accepts it. empty falls one cycle after the first wr_en.
- Read latency: rdata is valid one cycle after the accepted rd_en edge.
- overflow/underflow: high exactly one cycle, on the cycle after the rejected request (`req && flag |=> pulse`).

## Structure
- Package fifo_pkg: DATA_WIDTH/DEPTH defaults and a status struct {full, empty, almost_full, almost_empty}.
- Sub-module fifo_mem: a simple dual-port register array with one write port and one registered read port.
- Pointer, count and flag logic live in fifo_sync itself.
- Companion checker fifo_sync_assert is bound to the block and extends the existing property set with count/flag consistency checks.

## Test plan
- Reset then idle: rst low for 3 cycles → rdata=0, empty=1, full=0, count=0, overflow=underflow=0.
- Fill and drain, DEPTH=16, DATA_WIDTH=8: write 0x00..0x0F → full=1, count=16, almost_full from count=14. Read 16 → rdata 0x00..0x0F in order, one cycle after each rd_en; empty=1 at the end.
- Overflow: on a full FIFO, write 0xAA → overflow=1 next cycle only, count stays 16, err_sticky=2'b01. The 0xAA is never read out.
- Underflow: on an empty FIFO, assert rd_en → underflow=1 next cycle, rdata unchanged, err_sticky[1]=1. Then clr_err → err_sticky=0.
- Simultaneous access:
  - full + wr_en + rd_en → count=15, overflow pulse.
  - empty + both → count=1, underflow pulse.
  - count=5 + both → count=5, data order preserved.
- Wrap and reset mid-stream: run 40 writes/reads interleaved to wrap the pointers twice → data order preserved. Assert rst with count=7 → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the fifo_sync buffering block.
//   FIFO_DATA_WIDTH / FIFO_DEPTH : default width and depth.
//   fifo_status_t                : the registered flag bundle.
//   FIFO_STATUS_RST              : flag values held while in reset.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array, one write port and one
// registered read port.
//   clk, rst      : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata: write port, written on the rising edge when we=1
//   re/raddr      : read port, rdata loads mem[raddr] on the edge when re=1
//   rdata         : registered read data, holds its value when re=0
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**AW];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    // NOTE: the storage array has no reset; only the output register does.
    // Resetting the array would prevent mapping it onto RAM-style cells and
    // buys nothing, since the pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: every signal written in an always_comb gets a value on every
    // path (here the hold value first), otherwise a latch is inferred.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : fifo_mem

// File: rtl/fifo_sync_assert.sv
// fifo_sync_assert: property checker bound onto fifo_sync.
//   Inputs mirror the fifo_sync ports it observes; it drives nothing.
//   Checks flag/count consistency and the overflow/underflow pulse rules.
module fifo_sync_assert #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          wr_en,
    input logic          rd_en,
    input logic          full,
    input logic          empty,
    input logic [CW-1:0] count,
    input logic          overflow,
    input logic          underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst)
        !(full && empty));

    a_full_matches_count: assert property (@(posedge clk) disable iff (!rst)
        full == (count == DEPTH_C));

    a_empty_matches_count: assert property (@(posedge clk) disable iff (!rst)
        empty == (count == '0));

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst)
        count <= DEPTH_C);

    a_overflow_pulse: assert property (@(posedge clk) disable iff (!rst)
        (wr_en && full) |=> overflow);

    a_no_spurious_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en && full) |=> !overflow);

    a_underflow_pulse: assert property (@(posedge clk) disable iff (!rst)
        (rd_en && empty) |=> underflow);

    a_no_spurious_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(rd_en && empty) |=> !underflow);

endmodule : fifo_sync_assert

// File: rtl/fifo_sync.sv
// fifo_sync: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, registered
// overflow/underflow pulses and sticky error capture.
//   clk, rst          : clock, asynchronous active-low reset
//   wr_en, wdata      : write request and data (accepted iff !full)
//   rd_en             : read request (accepted iff !empty)
//   clr_err           : clears err_sticky (a same-cycle set wins)
//   rdata             : registered read data, valid the cycle after the read
//   full, empty       : count == DEPTH / count == 0
//   almost_full/empty : count >= AF_THRESH / count <= AE_THRESH
//   count             : current occupancy
//   overflow/underflow: one-cycle pulse after a rejected write/read
//   err_sticky        : {underflow seen, overflow seen}
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int  DEPTH      = FIFO_DEPTH,
    parameter int  AF_THRESH  = DEPTH - 2,
    parameter int  AE_THRESH  = 2,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [1:0]            err_sticky
);

    localparam int AW = $clog2(DEPTH);
    // One extra pointer bit tells a full FIFO from an empty one when the
    // address bits are equal; pointers wrap modulo 2*DEPTH.
    localparam int PW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    fifo_status_t  status_d, status_q;
    logic          overflow_d, overflow_q;
    logic          underflow_d, underflow_q;
    logic [1:0]    err_d, err_q;
    logic          wr_acc, rd_acc;

    // Acceptance uses the registered flags only. This alone yields the
    // simultaneous-access rules: when full the read wins, when empty the
    // write wins, otherwise both go through.
    always_comb begin
        wr_acc = wr_en && !status_q.full;
        rd_acc = rd_en && !status_q.empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags derive from the next count so that they and count always
        // change on the same edge.
        status_d.full         = (count_d == DEPTH_C);
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= AF_C);
        status_d.almost_empty = (count_d <= AE_C);

        overflow_d  = wr_en && status_q.full;
        underflow_d = rd_en && status_q.empty;

        // Clear first, then set, so a new error in the clearing cycle sticks.
        err_d = err_q;
        if (clr_err)     err_d = 2'b00;
        if (overflow_d)  err_d[0] = 1'b1;
        if (underflow_d) err_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            status_q    <= FIFO_STATUS_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            err_q       <= err_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign err_sticky   = err_q;

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed self-checking bench for fifo_sync
// (DEPTH=16, DATA_WIDTH=8, AF_THRESH=14, AE_THRESH=2).
bind fifo_sync fifo_sync_assert #(
    .DEPTH (DEPTH),
    .CW    (CW)
) u_fifo_sync_assert (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
);

module tb_fifo_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rdata;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;
    logic [1:0] err_sticky;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fifo_sync #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_THRESH  (14),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_sticky   (err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rdata"},        32'(rdata),        32'h00);
        check({tag, " empty"},        32'(empty),        32'd1);
        check({tag, " full"},         32'(full),         32'd0);
        check({tag, " count"},        32'(count),        32'd0);
        check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, " almost_full"},  32'(almost_full),  32'd0);
        check({tag, " overflow"},     32'(overflow),     32'd0);
        check({tag, " underflow"},    32'(underflow),    32'd0);
        check({tag, " err_sticky"},   32'(err_sticky),   32'd0);
    endtask

    task automatic write_n(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wdata = first + 8'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_expect(input int n, input logic [7:0] first, input string tag);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            check(tag, 32'(rdata), 32'(first + 8'(i)));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wdata   = 8'h00;
        rd_en   = 1'b0;
        clr_err = 1'b0;

        // Reset held for three cycles, then idle.
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b1;
        tick();
        check_reset_state("idle");

        // Fill with 0x00..0x0F; almost_full from count 14, full at 16.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wdata = 8'(i);
            tick();
            check("fill count",        32'(count),        32'(i + 1));
            check("fill empty",        32'(empty),        32'd0);
            check("fill full",         32'(full),         32'(i == 15));
            check("fill almost_full",  32'(almost_full),  32'(i >= 13));
            check("fill almost_empty", 32'(almost_empty), 32'(i <= 1));
        end

        // Overflow: 0xAA rejected, pulse for one cycle only.
        wdata = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("ovf pulse",  32'(overflow),   32'd1);
        check("ovf count",  32'(count),      32'd16);
        check("ovf sticky", 32'(err_sticky), 32'b01);
        tick();
        check("ovf pulse end", 32'(overflow), 32'd0);

        // Drain 0x00..0x0F in order; 0xAA never appears.
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            check("drain rdata", 32'(rdata), 32'(i));
            check("drain count", 32'(count), 32'(15 - i));
            check("drain empty", 32'(empty), 32'(i == 15));
        end
        rd_en = 1'b0;

        // Underflow: rdata held at 0x0F, sticky bit 1 set, then cleared.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf pulse",  32'(underflow),  32'd1);
        check("udf rdata",  32'(rdata),      32'h0F);
        check("udf sticky", 32'(err_sticky), 32'b11);
        check("udf count",  32'(count),      32'd0);
        tick();
        check("udf pulse end", 32'(underflow), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", 32'(err_sticky), 32'b00);

        // Full + write + read: read wins, count 15, overflow pulse.
        write_n(16, 8'h10);
        check("sim full pre", 32'(full), 32'd1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim full count", 32'(count),    32'd15);
        check("sim full ovf",   32'(overflow), 32'd1);
        check("sim full rdata", 32'(rdata),    32'h10);
        read_expect(15, 8'h11, "sim full drain");
        check("sim full empty", 32'(empty), 32'd1);

        // Empty + write + read: write wins, count 1, underflow pulse.
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h66;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim empty count", 32'(count),     32'd1);
        check("sim empty udf",   32'(underflow), 32'd1);
        check("sim empty rdata", 32'(rdata),     32'h1F);
        read_expect(1, 8'h66, "sim empty drain");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // count=5 + both: count unchanged, order preserved.
        write_n(5, 8'h30);
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h35;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim mid count", 32'(count), 32'd5);
        check("sim mid rdata", 32'(rdata), 32'h30);
        read_expect(5, 8'h31, "sim mid drain");
        check("sim mid empty", 32'(empty), 32'd1);

        // Interleaved stream: pointers wrap repeatedly, order preserved.
        write_n(3, 8'h40);
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wdata = 8'h43 + 8'(i);
            tick();
            check("wrap rdata", 32'(rdata), 32'h40 + 32'(i));
            check("wrap count", 32'(count), 32'd3);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Reset with count=7: outputs return to reset values at once.
        write_n(4, 8'hC0);
        check("pre-reset count", 32'(count), 32'd7);
        rst = 1'b0;
        #1;
        check_reset_state("mid reset");
        tick();
        rst = 1'b1;
        tick();
        check_reset_state("post reset");

        // Old contents are gone: the next read returns the next write.
        write_n(1, 8'h99);
        read_expect(1, 8'h99, "post reset data");
        check("post reset empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_sync
